// File: rtl/imx_arb.sv
// imx_arb: two-master arbiter in front of the core-bridge unit (CBU).
// Grants the fetch (I) or load/store (D) IMX port one at a time, muxes
// the granted request onto the CBU and steers the response back. Every
// grant ends in IDLE, which leaves a dead cycle between masters. A
// per-grant timeout turns a hung transfer into an error.
// Optional feature macro: IMX_ARB_RR_EN selects round-robin tie-break
// (otherwise fixed priority, D side wins).
module imx_arb #(
   parameter int dw     = 32,
   parameter int aw     = 32,
   parameter int TO_CYC = 255,
   parameter int TOW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   // fetch port
   input  logic [aw-1:0] iimx_adr_i,
   input  logic [dw-1:0] iimx_dat_i,
   input  logic          iimx_rqt_i,
   input  logic          iimx_we_i,
   input  logic [3:0]    iimx_sel_i,
   output logic          iimx_ack_o,
   output logic          iimx_err_o,
   output logic [dw-1:0] iimx_dat_o,
   output logic [aw-1:0] iimx_adr_o,
   // load/store port
   input  logic [aw-1:0] dimx_adr_i,
   input  logic [dw-1:0] dimx_dat_i,
   input  logic          dimx_rqt_i,
   input  logic          dimx_we_i,
   input  logic [3:0]    dimx_sel_i,
   output logic          dimx_ack_o,
   output logic          dimx_err_o,
   output logic [dw-1:0] dimx_dat_o,
   output logic [aw-1:0] dimx_adr_o,
   // CBU port
   output logic [aw-1:0] cbu_adr_o,
   output logic [dw-1:0] cbu_dat_o,
   output logic          cbu_rqt_o,
   output logic          cbu_we_o,
   output logic [3:0]    cbu_sel_o,
   input  logic          cbu_ack_i,
   input  logic          cbu_err_i,
   input  logic [dw-1:0] cbu_dat_i,
   input  logic [aw-1:0] cbu_adr_i
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t         state, state_nxt;
   logic [TOW-1:0] to_cnt;
   logic           pick_d;     // IDLE winner is the D side
   logic           any_rqt;
   logic           x_rqt;      // request line of the granted master
   logic [aw-1:0]  x_adr;      // address of the granted master
   logic           rsp_hit;    // response that belongs to the granted transfer
   logic           to_exp;     // last cycle the grant may wait for a response

   assign any_rqt = iimx_rqt_i | dimx_rqt_i;

`ifdef IMX_ARB_RR_EN
   logic last;                 // 1 = D was granted last, 0 = I

   // remember the side granted on each arbitration
   always_ff @(posedge clk) begin
      if (rst)                          last <= 1'b0;
      else if (state == IDLE && any_rqt) last <= pick_d;
   end

   // on a tie the side not granted last wins
   assign pick_d = dimx_rqt_i & (~iimx_rqt_i | ~last);
`else
   // fixed priority: D wins any tie
   assign pick_d = dimx_rqt_i;
`endif

   assign x_rqt   = (state == GNT_I) ? iimx_rqt_i :
                    (state == GNT_D) ? dimx_rqt_i : 1'b0;
   assign x_adr   = (state == GNT_D) ? dimx_adr_i : iimx_adr_i;
   assign rsp_hit = (cbu_ack_i | cbu_err_i) && (cbu_adr_i == x_adr);
   assign to_exp  = (to_cnt == TOW'(TO_CYC - 1));

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // timeout counter: cleared while idle, counts grant cycles without a response
   always_ff @(posedge clk) begin
      if (rst || state == IDLE) to_cnt <= '0;
      else if (!rsp_hit)        to_cnt <= to_cnt + 1'b1;
   end

   // next state: arbitrate in IDLE, release on response, cancel or timeout
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_rqt) state_nxt = pick_d ? GNT_D : GNT_I;
         GNT_I,
         GNT_D:   if (!x_rqt || rsp_hit || to_exp) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: request mux to CBU and response steering to the granted master
   always_comb begin
      cbu_adr_o  = '0;
      cbu_dat_o  = '0;
      cbu_rqt_o  = 1'b0;
      cbu_we_o   = 1'b0;
      cbu_sel_o  = '0;
      iimx_ack_o = 1'b0;
      iimx_err_o = 1'b0;
      dimx_ack_o = 1'b0;
      dimx_err_o = 1'b0;
      case (state)
         GNT_I: begin
            cbu_adr_o  = iimx_adr_i;
            cbu_dat_o  = iimx_dat_i;
            cbu_rqt_o  = iimx_rqt_i;
            cbu_we_o   = iimx_we_i;
            cbu_sel_o  = iimx_sel_i;
            // a cancelled request forwards nothing; a response beats expiry
            iimx_ack_o = ~rst & iimx_rqt_i & rsp_hit & cbu_ack_i;
            iimx_err_o = ~rst & iimx_rqt_i & ((rsp_hit & cbu_err_i) | (~rsp_hit & to_exp));
         end
         GNT_D: begin
            cbu_adr_o  = dimx_adr_i;
            cbu_dat_o  = dimx_dat_i;
            cbu_rqt_o  = dimx_rqt_i;
            cbu_we_o   = dimx_we_i;
            cbu_sel_o  = dimx_sel_i;
            dimx_ack_o = ~rst & dimx_rqt_i & rsp_hit & cbu_ack_i;
            dimx_err_o = ~rst & dimx_rqt_i & ((rsp_hit & cbu_err_i) | (~rsp_hit & to_exp));
         end
         default: ;
      endcase
   end

   // response data/address go to both masters; qualified by ack/err only
   assign iimx_dat_o = cbu_dat_i;
   assign iimx_adr_o = cbu_adr_i;
   assign dimx_dat_o = cbu_dat_i;
   assign dimx_adr_o = cbu_adr_i;

endmodule

// File: tb/tb_imx_arb.sv
// Directed bench for imx_arb. The CBU side is driven by hand, cycle by
// cycle; TO_CYC is shortened to 4 so the timeout case stays short.
module tb_imx_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] iimx_adr_i = '0, iimx_dat_i = '0;
   logic        iimx_rqt_i = 1'b0, iimx_we_i = 1'b0;
   logic [3:0]  iimx_sel_i = '0;
   logic        iimx_ack_o, iimx_err_o;
   logic [31:0] iimx_dat_o, iimx_adr_o;
   logic [31:0] dimx_adr_i = '0, dimx_dat_i = '0;
   logic        dimx_rqt_i = 1'b0, dimx_we_i = 1'b0;
   logic [3:0]  dimx_sel_i = '0;
   logic        dimx_ack_o, dimx_err_o;
   logic [31:0] dimx_dat_o, dimx_adr_o;
   logic [31:0] cbu_adr_o, cbu_dat_o;
   logic        cbu_rqt_o, cbu_we_o;
   logic [3:0]  cbu_sel_o;
   logic        cbu_ack_i = 1'b0, cbu_err_i = 1'b0;
   logic [31:0] cbu_dat_i = '0, cbu_adr_i = '0;

   int checks = 0;
   int errors = 0;

   imx_arb #(.dw(32), .aw(32), .TO_CYC(4), .TOW(8)) dut (
      .clk(clk), .rst(rst),
      .iimx_adr_i(iimx_adr_i), .iimx_dat_i(iimx_dat_i), .iimx_rqt_i(iimx_rqt_i),
      .iimx_we_i(iimx_we_i), .iimx_sel_i(iimx_sel_i),
      .iimx_ack_o(iimx_ack_o), .iimx_err_o(iimx_err_o),
      .iimx_dat_o(iimx_dat_o), .iimx_adr_o(iimx_adr_o),
      .dimx_adr_i(dimx_adr_i), .dimx_dat_i(dimx_dat_i), .dimx_rqt_i(dimx_rqt_i),
      .dimx_we_i(dimx_we_i), .dimx_sel_i(dimx_sel_i),
      .dimx_ack_o(dimx_ack_o), .dimx_err_o(dimx_err_o),
      .dimx_dat_o(dimx_dat_o), .dimx_adr_o(dimx_adr_o),
      .cbu_adr_o(cbu_adr_o), .cbu_dat_o(cbu_dat_o), .cbu_rqt_o(cbu_rqt_o),
      .cbu_we_o(cbu_we_o), .cbu_sel_o(cbu_sel_o),
      .cbu_ack_i(cbu_ack_i), .cbu_err_i(cbu_err_i),
      .cbu_dat_i(cbu_dat_i), .cbu_adr_i(cbu_adr_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic        exp_d;
   logic [31:0] ea;

   initial begin
      // ---------------- reset
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_cbu_rqt", cbu_rqt_o, 0);
      chk("rst_cbu_adr", cbu_adr_o, 0);
      chk("rst_acks",    {iimx_ack_o, iimx_err_o, dimx_ack_o, dimx_err_o}, 0);

      // ---------------- single fetch, ack in cycle 3
      iimx_rqt_i = 1'b1; iimx_adr_i = 32'h0000_0100; iimx_sel_i = 4'hF;
      #1;
      chk("f_c0_idle", cbu_rqt_o, 0);
      tick();
      chk("f_c1_rqt", cbu_rqt_o, 1);
      chk("f_c1_adr", cbu_adr_o, 32'h100);
      chk("f_c1_sel", cbu_sel_o, 4'hF);
      tick();
      chk("f_c2_noack", iimx_ack_o, 0);
      tick();
      cbu_ack_i = 1'b1; cbu_adr_i = 32'h100; cbu_dat_i = 32'hDEAD_BEEF;
      #1;
      chk("f_c3_ack",  iimx_ack_o, 1);
      chk("f_c3_dat",  iimx_dat_o, 32'hDEAD_BEEF);
      chk("f_c3_dack", dimx_ack_o, 0);
      tick();
      cbu_ack_i = 1'b0; iimx_rqt_i = 1'b0;
      #1;
      chk("f_c4_idle", cbu_rqt_o, 0);

      // ---------------- tie, both requesting continuously, zero-wait slave
      iimx_rqt_i = 1'b1; iimx_adr_i = 32'h200;
      dimx_rqt_i = 1'b1; dimx_adr_i = 32'h300;
      #1;
      for (int g = 0; g < 4; g++) begin
`ifdef IMX_ARB_RR_EN
         exp_d = (g % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         ea = exp_d ? 32'h300 : 32'h200;
         chk("tie_gap", cbu_rqt_o, 0);
         tick();
         chk("tie_rqt", cbu_rqt_o, 1);
         chk("tie_adr", cbu_adr_o, ea);
         cbu_ack_i = 1'b1; cbu_adr_i = ea; cbu_dat_i = 32'h1000 + g;
         #1;
         chk("tie_dack", dimx_ack_o, exp_d);
         chk("tie_iack", iimx_ack_o, !exp_d);
         tick();
         cbu_ack_i = 1'b0;
         #1;
      end
      iimx_rqt_i = 1'b0; dimx_rqt_i = 1'b0;
      tick();

      // ---------------- cancel of D, pending I then granted
      dimx_rqt_i = 1'b1; dimx_adr_i = 32'h400;
      #1;
      tick();
      chk("c_c1_adr", cbu_adr_o, 32'h400);
      iimx_rqt_i = 1'b1; iimx_adr_i = 32'h500;
      tick();
      dimx_rqt_i = 1'b0;
      #1;
      chk("c_c2_rqt",  cbu_rqt_o, 0);
      chk("c_c2_dack", dimx_ack_o, 0);
      tick();
      chk("c_c3_idle", cbu_rqt_o, 0);
      chk("c_c3_dack", dimx_ack_o, 0);
      tick();
      chk("c_c4_rqt", cbu_rqt_o, 1);
      chk("c_c4_adr", cbu_adr_o, 32'h500);
      cbu_ack_i = 1'b1; cbu_adr_i = 32'h500;
      #1;
      chk("c_c4_iack", iimx_ack_o, 1);
      tick();
      cbu_ack_i = 1'b0; iimx_rqt_i = 1'b0;
      #1;

      // ---------------- timeout, TO_CYC = 4: err 4 cycles after the grant
      iimx_rqt_i = 1'b1; iimx_adr_i = 32'h600;
      #1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("t_wait_rqt", cbu_rqt_o, 1);
         chk("t_wait_err", iimx_err_o, 0);
      end
      tick();
      chk("t_c4_err", iimx_err_o, 1);
      chk("t_c4_ack", iimx_ack_o, 0);
      tick();
      chk("t_c5_err",  iimx_err_o, 0);
      chk("t_c5_idle", cbu_rqt_o, 0);
      iimx_rqt_i = 1'b0;
      #1;

      // ---------------- address mismatch drops response, grant holds
      iimx_rqt_i = 1'b1; iimx_adr_i = 32'h700;
      #1;
      tick();
      cbu_ack_i = 1'b1; cbu_adr_i = 32'h704;
      #1;
      chk("m_c1_ack", iimx_ack_o, 0);
      tick();
      chk("m_c2_hold", cbu_rqt_o, 1);
      chk("m_c2_ack",  iimx_ack_o, 0);
      tick();
      cbu_adr_i = 32'h700;
      #1;
      chk("m_c3_ack", iimx_ack_o, 1);
      tick();
      cbu_ack_i = 1'b0; iimx_rqt_i = 1'b0;
      #1;

      // ---------------- response on the expiry cycle wins over timeout
      iimx_rqt_i = 1'b1; iimx_adr_i = 32'h800;
      #1;
      repeat (4) tick();
      cbu_ack_i = 1'b1; cbu_adr_i = 32'h800;
      #1;
      chk("x_c4_ack", iimx_ack_o, 1);
      chk("x_c4_err", iimx_err_o, 0);
      tick();
      iimx_rqt_i = 1'b0;
      #1;
      // response arriving in IDLE is discarded
      chk("idle_rsp", iimx_ack_o, 0);
      cbu_ack_i = 1'b0;

      // ---------------- reset pulse while in GNT_D
      dimx_rqt_i = 1'b1; dimx_adr_i = 32'h900; dimx_we_i = 1'b1;
      #1;
      tick();
      chk("r_c1_gnt", cbu_rqt_o, 1);
      rst = 1'b1; cbu_ack_i = 1'b1; cbu_adr_i = 32'h900;
      #1;
      chk("r_c1_forced", dimx_ack_o, 0);
      tick();
      rst = 1'b0; cbu_ack_i = 1'b0;
      #1;
      chk("r_c2_rqt", cbu_rqt_o, 0);
      chk("r_c2_adr", cbu_adr_o, 0);
      chk("r_c2_we",  cbu_we_o, 0);
      chk("r_c2_acks", {iimx_ack_o, iimx_err_o, dimx_ack_o, dimx_err_o}, 0);
      tick();
      chk("r_c3_rqt", cbu_rqt_o, 1);
      chk("r_c3_adr", cbu_adr_o, 32'h900);
      chk("r_c3_we",  cbu_we_o, 1);
      // simultaneous ack and err are both forwarded
      cbu_ack_i = 1'b1; cbu_err_i = 1'b1; cbu_adr_i = 32'h900;
      #1;
      chk("r_c3_ack", dimx_ack_o, 1);
      chk("r_c3_err", dimx_err_o, 1);
      tick();
      cbu_ack_i = 1'b0; cbu_err_i = 1'b0; dimx_rqt_i = 1'b0;
      #1;
      chk("r_c4_idle", cbu_rqt_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imx_arb.md
# imx_arb

Two-master arbiter sharing the single core-bridge unit (CBU) between the instruction-fetch IMX port and the load/store IMX port. It sits between the core's fetch and LSU interfaces and the CBU request/response port. It grants one master at a time, muxes its request onto the CBU and steers the CBU response back. It inserts a dead cycle between grants so the Wishbone cycle drops between masters, and it terminates hung transactions with an error.

## Interface
- `dw`, 32, data width
- `aw`, 32, address width
- `TO_CYC`, 255, cycles granted without ack/err before forced error (1..2^TOW-1)
- `TOW`, 8, timeout counter width

- `clk`  in  1  core clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `iimx_adr_i`, `iimx_dat_i`, `iimx_rqt_i`, `iimx_we_i`, `iimx_sel_i`  in  aw/dw/1/1/4  fetch request
- `iimx_ack_o`, `iimx_err_o`  out  1  fetch response
- `iimx_dat_o`, `iimx_adr_o`  out  dw/aw  fetch response data/address
- `dimx_*`  same set as `iimx_*`  LSU port
- `cbu_adr_o`, `cbu_dat_o`, `cbu_rqt_o`, `cbu_we_o`, `cbu_sel_o`  out  aw/dw/1/1/4  request to CBU
- `cbu_ack_i`, `cbu_err_i`  in  1  CBU response
- `cbu_dat_i`, `cbu_adr_i`  in  dw/aw  CBU response data/address

## Operation
- State machine states: IDLE, GNT_I, GNT_D. Registers: state, `last` (last granted side), timeout counter `to_cnt`.
- IDLE behaviour:
  - `cbu_rqt_o`=0, and `cbu_adr_o`/`cbu_dat_o`/`cbu_we_o`/`cbu_sel_o`=0.
  - Winner selection: if any rqt is high, the winner is chosen and the state moves to GNT_winner at the next edge. `last` is updated to the winner, and `to_cnt` is cleared.
  - Tie-break rule is set by Configuration.
- GNT_x behaviour:
  - `cbu_*_o` are driven combinationally from master x's inputs. `cbu_rqt_o` = `x_rqt_i`.
  - Valid response: `cbu_ack_i` or `cbu_err_i` is high and `cbu_adr_i == x_adr_i`. It is forwarded the same cycle to `x_ack_o`/`x_err_o`, and the state returns to IDLE.
  - Address mismatch: the response is dropped and the state holds.
  - Cancel: if `x_rqt_i`=0, the state returns to IDLE and nothing is forwarded.
  - Timeout: `to_cnt` increments each GNT cycle with no valid response. When `to_cnt == TO_CYC-1` and no response arrives, `x_err_o`=1 for one cycle and the state returns to IDLE.
- Ungranted master: ack/err always 0.
- Response data/address: `cbu_dat_i`/`cbu_adr_i` are broadcast to both `*_dat_o`/`*_adr_o` at all times. They are valid only alongside ack/err.
- Response while idle: ack/err arriving in IDLE is discarded.
- Simultaneous ack and err: both are forwarded, and the master treats err as dominant.
- Simultaneous response and timeout expiry: the response wins, and no timeout err is raised.

## Timing
- Reset values: state=IDLE, `last`=I, `to_cnt`=0. Consequently all `*_ack_o`, `*_err_o` and `cbu_*_o` read 0 from the cycle after the reset edge.
- During `rst`=1, ack/err outputs are forced to 0.
- Reset mid-transaction: IDLE at the next edge; no response is forwarded, and the pending CBU transfer is abandoned.
- Grant latency: rqt is sampled in IDLE at cycle 0, and `cbu_rqt_o` is high in cycle 1.
- End-to-end latency: with the CBU's registered request and response, a zero-wait slave gives a master ack in cycle 3.
- Back-to-back: after the ack cycle, one IDLE dead cycle follows. The next grant is therefore 2 cycles after the ack, and the earliest next `cbu_rqt_o` is ack+2.
- Master contract: a master holds adr/dat/we/sel stable while rqt is high, and drops rqt only after ack/err or to cancel.

## Configuration
- `IMX_ARB_RR_EN` defined: round-robin. On a tie in IDLE, the side not equal to `last` wins.
- `IMX_ARB_RR_EN` undefined: fixed priority. On a tie the D side always wins, and the `last` register is not implemented.
- All other behaviour is identical in both builds.

## Test plan
- Single fetch: `iimx_rqt_i`=1, adr 0x0000_0100, zero-wait slave returns 0xDEAD_BEEF -> `iimx_ack_o` in cycle 3 with `iimx_dat_o`=0xDEAD_BEEF; `dimx_ack_o` stays 0.
- Tie, RR: both rqt high continuously, each transaction zero-wait.
  - Built with `IMX_ARB_RR_EN`: grants go D, I, D, I, with `cbu_rqt_o` low for one cycle between grants.
  - Built without it: D is granted on every arbitration.
- Cancel: D is granted, then `dimx_rqt_i` drops in cycle 2 before any ack -> state IDLE in cycle 3, no `dimx_ack_o`, and a pending I request is granted in cycle 4.
- Timeout: `TO_CYC`=4, slave never acks -> `iimx_err_o`=1 for exactly one cycle, 4 cycles after the grant, then IDLE.
- Address mismatch: in GNT_I, `cbu_ack_i`=1 arrives with `cbu_adr_i`≠`iimx_adr_i` -> no ack is forwarded and the grant holds. A later matching ack is forwarded.
- Reset mid-operation: `rst` is pulsed for 1 cycle while in GNT_D -> all outputs are 0 the next cycle, and a new request is granted normally afterwards.
